// File: rtl/bitty_seq_pkg.sv
// Shared definitions for the bitty instruction sequencer: FSM states,
// Wishbone word offsets (byte address >> 2) and CTRL bit positions.
package bitty_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_PC     = 8'h02;
    localparam logic [7:0] REG_LEN    = 8'h03;
    localparam logic [7:0] REG_RESULT = 8'h04;
    localparam logic [7:0] REG_COUNT  = 8'h05;
    localparam logic [7:0] REG_WDT    = 8'h06;
    localparam logic [7:0] REG_IMEM   = 8'h20;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_STOP    = 1;
    localparam int unsigned CTRL_LOOP    = 2;
    localparam int unsigned CTRL_IRQ_CLR = 3;

endpackage

// File: rtl/bitty_seq_imem.sv
// Instruction memory: one synchronous write port (blocked while the sequencer
// is busy) and two asynchronous read taps (bus readback and instruction fetch).
module bitty_seq_imem #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic            busy_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [BITS-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_a_i,
    output logic [BITS-1:0] rdata_a_o,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [BITS-1:0] rdata_b_o
);

    logic [BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i && !busy_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/bitty_seq.sv
// bitty_seq: Wishbone-loaded instruction sequencer feeding the bitty core one
// instruction at a time. Optional watchdog in WAIT: define BITTY_SEQ_WDT_EN.
module bitty_seq
    import bitty_seq_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            core_run,
    output logic [BITS-1:0] core_instr,
    input  logic            core_done,
    input  logic [BITS-1:0] core_d_out,
    output logic            busy,
    output logic            irq
);

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW:0]     len_q, len_d;
    logic [BITS-1:0] result_q, result_d;
    logic [15:0]     count_q, count_d;
    logic            err_q, err_d;
    logic            irq_q, irq_d;
    logic            loop_q, loop_d;
    logic            stop_q, stop_d;
    logic            run_q, run_d;
    logic [BITS-1:0] instr_q, instr_d;
    logic            ack_q;
    logic [31:0]     rdata_q, rdata_d;
`ifdef BITTY_SEQ_WDT_EN
    logic [15:0]     wdt_q, wdt_d;
`endif

    logic            wb_acc, wr_en, rd_en;
    logic [7:0]      word;
    logic            imem_hit;
    logic [AW-1:0]   imem_addr;
    logic [BITS-1:0] imem_rdata, fetch_instr;
    logic            ctrl_wr, start_wr, stop_wr, irq_clr_wr, len_wr, imem_wr;
    logic [AW:0]     pc_inc;
    logic            unused_bits;

    // An access is taken once; the ack cycle itself is never a new access.
    assign wb_acc    = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr_en     = wb_acc & wbs_we_i & (|wbs_sel_i);
    assign rd_en     = wb_acc & ~wbs_we_i;
    assign word      = wbs_adr_i[9:2];
    assign imem_hit  = (word >= REG_IMEM) &&
                       ({1'b0, word} < ({1'b0, REG_IMEM} + 9'(DEPTH)));
    assign imem_addr = AW'(word - REG_IMEM);

    assign ctrl_wr    = wr_en && (word == REG_CTRL);
    assign start_wr   = ctrl_wr && wbs_dat_i[CTRL_START];
    assign stop_wr    = ctrl_wr && wbs_dat_i[CTRL_STOP];
    assign irq_clr_wr = ctrl_wr && wbs_dat_i[CTRL_IRQ_CLR];
    assign len_wr     = wr_en && (word == REG_LEN);
    assign imem_wr    = wr_en && imem_hit;

    assign busy        = (state_q != IDLE);
    assign pc_inc      = {1'b0, pc_q} + 1'b1;
    assign unused_bits = ^{wbs_adr_i[31:10], wbs_adr_i[1:0], wbs_dat_i[31:BITS]};

    bitty_seq_imem #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk       (clk),
        .we_i      (imem_wr),
        .busy_i    (busy),
        .waddr_i   (imem_addr),
        .wdata_i   (wbs_dat_i[BITS-1:0]),
        .raddr_a_i (imem_addr),
        .rdata_a_o (imem_rdata),
        .raddr_b_i (pc_d),
        .rdata_b_o (fetch_instr)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        result_d = result_q;
        count_d  = count_q;
        err_d    = err_q;
        irq_d    = irq_q;
        loop_d   = loop_q;
        stop_d   = stop_q;
`ifdef BITTY_SEQ_WDT_EN
        wdt_d    = wdt_q;
`endif
        if (len_wr && !busy) len_d = wbs_dat_i[AW:0];
        if (irq_clr_wr)      irq_d = 1'b0;
        if (imem_wr && busy) err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_wr && !stop_wr) begin
                    irq_d = 1'b0;
                    if (len_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        pc_d    = '0;
                        loop_d  = wbs_dat_i[CTRL_LOOP];
                        stop_d  = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (stop_wr) stop_d = 1'b1;
`ifdef BITTY_SEQ_WDT_EN
                wdt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (stop_wr) stop_d = 1'b1;
                if (core_done) begin
                    result_d = core_d_out;
                    count_d  = count_q + 16'd1;
                    pc_d     = pc_inc[AW-1:0];
                    // A pending or same-cycle stop ends the program on this done.
                    if (stop_q || stop_wr) begin
                        state_d = DONE;
                    end else if (pc_inc < len_q) begin
                        state_d = ISSUE;
                    end else if (loop_q) begin
                        pc_d    = '0;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
`ifdef BITTY_SEQ_WDT_EN
                else if (wdt_q == 16'hFFFF) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdt_d = wdt_q + 16'd1;
                end
`endif
            end
            DONE: begin
                irq_d   = 1'b1;
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // run/instr are registered on entry to ISSUE so both are valid together.
    always_comb begin
        run_d   = (state_d == ISSUE);
        instr_d = (state_d == ISSUE) ? fetch_instr : instr_q;
    end

    always_comb begin
        rdata_d = '0;
        case (word)
            REG_STATUS: rdata_d = 32'({err_q, irq_q, state_q});
            REG_PC:     rdata_d = 32'(pc_q);
            REG_LEN:    rdata_d = 32'(len_q);
            REG_RESULT: rdata_d = 32'(result_q);
            REG_COUNT:  rdata_d = 32'(count_q);
`ifdef BITTY_SEQ_WDT_EN
            REG_WDT:    rdata_d = 32'(wdt_q);
`endif
            default:    if (imem_hit) rdata_d = 32'(imem_rdata);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            loop_q   <= 1'b0;
            stop_q   <= 1'b0;
            run_q    <= 1'b0;
            instr_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
`ifdef BITTY_SEQ_WDT_EN
            wdt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            result_q <= result_d;
            count_q  <= count_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
            loop_q   <= loop_d;
            stop_q   <= stop_d;
            run_q    <= run_d;
            instr_q  <= instr_d;
            ack_q    <= wb_acc;
            rdata_q  <= rd_en ? rdata_d : '0;
`ifdef BITTY_SEQ_WDT_EN
            wdt_q    <= wdt_d;
`endif
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = rdata_q;
    assign core_run   = run_q;
    assign core_instr = instr_q;
    assign irq        = irq_q;

endmodule
